// File: rtl/clk_div_ctrl.sv
// Programmable divide-by-N clock-enable controller. Divisor changes are applied only at period boundaries.
// Define PERIOD_CNT_EN to add the period_cnt output, which counts completed output periods.
module clk_div_ctrl #(
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 50000000,
    parameter int MIN_DIV     = 2
) (
    input  logic             clock_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             div_err,
    output logic             clock_out,
    output logic             tick,
`ifdef PERIOD_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic             busy
);

    // state  | meaning
    // IDLE   | counter held at 0, divisor writes apply immediately
    // RUN    | counting with div_act
    // PEND   | counting, div_pend waits for the end of the current period
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] div_act, div_act_nxt;
    logic [WIDTH-1:0] div_pend, div_pend_nxt;
    logic             counting;
    logic             last;
    logic             xfer;
    logic             div_bad;

    assign counting = (state == S_RUN) || (state == S_PEND);
    assign last     = (cnt == div_act - ONE);
    assign xfer     = div_valid && div_ready;
    assign div_bad  = (div_in < DIV_MIN);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        div_act_nxt  = div_act;
        div_pend_nxt = div_pend;
        case (state)
            S_IDLE: begin
                if (xfer && !div_bad) begin
                    div_act_nxt = div_in;
                end
                if (start && !stop) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                cnt_nxt = last ? '0 : cnt + ONE;
                if (stop) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    if (xfer && !div_bad) begin
                        div_act_nxt = div_in;
                    end
                end else if (xfer && !div_bad) begin
                    state_nxt    = S_PEND;
                    div_pend_nxt = div_in;
                end
            end
            S_PEND: begin
                cnt_nxt = last ? '0 : cnt + ONE;
                // A stop while a divisor is queued still commits it, so it is not lost.
                if (stop) begin
                    state_nxt   = S_IDLE;
                    cnt_nxt     = '0;
                    div_act_nxt = div_pend;
                end else if (last) begin
                    state_nxt   = S_RUN;
                    div_act_nxt = div_pend;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            div_act   <= DIV_RST;
            div_pend  <= '0;
            clock_out <= 1'b0;
            tick      <= 1'b0;
            div_err   <= 1'b0;
            busy      <= 1'b0;
            div_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div_act   <= div_act_nxt;
            div_pend  <= div_pend_nxt;
            // High for the first floor(N/2) counts, so odd divisors spend the extra cycle low.
            clock_out <= counting && !stop && (cnt < (div_act >> 1));
            tick      <= counting && last;
            div_err   <= xfer && div_bad;
            busy      <= (state_nxt != S_IDLE);
            div_ready <= (state_nxt != S_PEND);
        end
    end

`ifdef PERIOD_CNT_EN
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if ((state == S_IDLE) && (state_nxt == S_RUN)) begin
            period_cnt <= '0;
        end else if (counting && last) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl, built with DEFAULT_DIV=4.
// Expected output samples are queued from the stimulus and popped one per cycle.
module tb_clk_div_ctrl;

    localparam int WIDTH = 28;

    logic             clock_in;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             div_err;
    logic             clock_out;
    logic             tick;
    logic             busy;
`ifdef PERIOD_CNT_EN
    logic [15:0]      period_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Each entry is {busy, clock_out, tick, div_ready, div_err}.
    logic [4:0] exp_q[$];

    clk_div_ctrl #(
        .WIDTH(WIDTH),
        .DEFAULT_DIV(4),
        .MIN_DIV(2)
    ) dut (
        .clock_in(clock_in),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .div_in(div_in),
        .div_valid(div_valid),
        .div_ready(div_ready),
        .div_err(div_err),
        .clock_out(clock_out),
        .tick(tick),
`ifdef PERIOD_CNT_EN
        .period_cnt(period_cnt),
`endif
        .busy(busy)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [4:0] obs();
        return {busy, clock_out, tick, div_ready, div_err};
    endfunction

    // Sample k after the start edge sits at count k mod n of the running period.
    function automatic void push_pattern(int n, int count);
        for (int k = 0; k < count; k++) begin
            exp_q.push_back({1'b1, ((k % n) < (n / 2)), ((k % n) == (n - 1)), 1'b1, 1'b0});
        end
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clock_in);
        #1 start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clock_in);
        #1 stop = 1'b0;
    endtask

    task automatic load_div(input int v);
        div_in    = WIDTH'(v);
        div_valid = 1'b1;
        @(posedge clock_in);
        #1 div_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        div_in    = '0;
        div_valid = 1'b0;
        repeat (2) @(posedge clock_in);
        #1;
        n_cmp++;
        if (obs() !== 5'b00010) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b exp=%b", obs(), 5'b00010);
        end
        @(negedge clock_in);
        rst_n = 1'b1;
    endtask

    task automatic test_default_run();
        logic [4:0] e;
        do_start();
        push_pattern(4, 12);
        for (int k = 0; k < 12; k++) begin
            @(posedge clock_in);
            @(negedge clock_in);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL default_run k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
        do_stop();
        @(negedge clock_in);
        n_cmp++;
        if ({busy, clock_out} !== 2'b00) begin
            n_bad++;
            $display("FAIL stop_in_run got=%b exp=00", {busy, clock_out});
        end
    endtask

    task automatic test_idle_load();
        logic [4:0] e;
        div_in    = WIDTH'(6);
        div_valid = 1'b1;
        #1;
        n_cmp++;
        if (div_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_ready got=%b exp=1", div_ready);
        end
        @(posedge clock_in);
        #1 div_valid = 1'b0;
        do_start();
        push_pattern(6, 18);
        for (int k = 0; k < 18; k++) begin
            @(posedge clock_in);
            @(negedge clock_in);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL idle_load k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
        do_stop();
        load_div(4);
    endtask

    task automatic test_pend_load();
        logic [4:0] e;
        do_start();
        push_pattern(4, 4);
        push_pattern(8, 16);
        exp_q[1][1] = 1'b0;
        exp_q[2][1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 1) begin
                div_in    = WIDTH'(8);
                div_valid = 1'b1;
            end else if (k == 2) begin
                div_in = WIDTH'(2);
            end else if (k == 3) begin
                div_valid = 1'b0;
            end
            @(posedge clock_in);
            @(negedge clock_in);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL pend_load k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
        do_stop();
    endtask

    task automatic test_bad_div();
        logic [4:0] e;
        @(negedge clock_in);
        div_in    = '0;
        div_valid = 1'b1;
        @(posedge clock_in);
        #1 div_valid = 1'b0;
        @(negedge clock_in);
        n_cmp++;
        if ({busy, div_err} !== 2'b01) begin
            n_bad++;
            $display("FAIL idle_bad_err got=%b exp=01", {busy, div_err});
        end
        @(negedge clock_in);
        n_cmp++;
        if (div_err !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_bad_err_end got=%b exp=0", div_err);
        end
        do_start();
        push_pattern(8, 16);
        exp_q[1][0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 1) begin
                div_in    = WIDTH'(1);
                div_valid = 1'b1;
            end else if (k == 2) begin
                div_valid = 1'b0;
            end
            @(posedge clock_in);
            @(negedge clock_in);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL run_bad_div k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
        do_stop();
        load_div(4);
    endtask

    task automatic test_start_stop();
        logic [4:0] e;
        @(negedge clock_in);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clock_in);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clock_in);
        n_cmp++;
        if ({busy, clock_out} !== 2'b00) begin
            n_bad++;
            $display("FAIL start_stop_idle got=%b exp=00", {busy, clock_out});
        end
        do_start();
        repeat (3) @(posedge clock_in);
        #1;
        stop      = 1'b1;
        div_in    = WIDTH'(6);
        div_valid = 1'b1;
        @(posedge clock_in);
        #1;
        stop      = 1'b0;
        div_valid = 1'b0;
        @(negedge clock_in);
        n_cmp++;
        if ({busy, clock_out} !== 2'b00) begin
            n_bad++;
            $display("FAIL stop_with_div got=%b exp=00", {busy, clock_out});
        end
        do_start();
        push_pattern(6, 12);
        for (int k = 0; k < 12; k++) begin
            @(posedge clock_in);
            @(negedge clock_in);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL stop_div_commit k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
        do_stop();
        // Queue a divisor, then stop before the period ends: it must still take effect.
        do_start();
        div_in    = WIDTH'(8);
        div_valid = 1'b1;
        @(posedge clock_in);
        #1;
        div_valid = 1'b0;
        do_stop();
        do_start();
        push_pattern(8, 16);
        for (int k = 0; k < 16; k++) begin
            @(posedge clock_in);
            @(negedge clock_in);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL pend_stop_commit k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
        do_stop();
        load_div(4);
    endtask

    task automatic test_reset_mid();
        logic [4:0] e;
        load_div(6);
        do_start();
        div_in    = WIDTH'(8);
        div_valid = 1'b1;
        @(posedge clock_in);
        #1 div_valid = 1'b0;
        @(posedge clock_in);
        @(negedge clock_in);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 5'b00010) begin
            n_bad++;
            $display("FAIL async_reset got=%b exp=%b", obs(), 5'b00010);
        end
        @(negedge clock_in);
        rst_n = 1'b1;
        do_start();
        push_pattern(4, 8);
        for (int k = 0; k < 8; k++) begin
            @(posedge clock_in);
            @(negedge clock_in);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL after_reset k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
        do_stop();
    endtask

`ifdef PERIOD_CNT_EN
    task automatic test_period_cnt();
        @(negedge clock_in);
        do_start();
        repeat (40) @(posedge clock_in);
        @(negedge clock_in);
        n_cmp++;
        if (period_cnt !== 16'd10) begin
            n_bad++;
            $display("FAIL period_cnt_10 got=%0d exp=10", period_cnt);
        end
        do_stop();
        do_start();
        @(negedge clock_in);
        n_cmp++;
        if (period_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL period_cnt_restart got=%0d exp=0", period_cnt);
        end
        do_stop();
    endtask
`endif

    initial begin
        test_reset();
        test_default_run();
        test_idle_load();
        test_pend_load();
        test_bad_div();
        test_start_stop();
        test_reset_mid();
`ifdef PERIOD_CNT_EN
        test_period_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
